// File: rtl/dsp_ar_channel.sv
// rtl/dsp_ar_channel.sv - per-master AR dispatcher with slave decode, output register and in-order slave-id FIFO
module dsp_ar_channel #(
    parameter int SLV_AMT           = 2,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int SLV_ID_W          = $clog2(SLV_AMT),
    parameter int DSP_AR_DEPTH      = 4
) (
    input  logic                                    ACLK_i,
    input  logic                                    ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]               m_ARID_i,
    input  logic [ADDR_WIDTH-1:0]                   m_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]                m_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]             m_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]            m_ARSIZE_i,
    input  logic                                    m_ARVALID_i,
    output logic                                    m_ARREADY_o,
    input  logic                                    m_RVALID_i,
    input  logic                                    m_RREADY_i,
    input  logic                                    m_RLAST_i,
    output logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_ARID_o,
    output logic [ADDR_WIDTH*SLV_AMT-1:0]           sa_ARADDR_o,
    output logic [TRANS_BURST_W*SLV_AMT-1:0]        sa_ARBURST_o,
    output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]     sa_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]    sa_ARSIZE_o,
    output logic [SLV_AMT-1:0]                      sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]                      sa_ARREADY_i,
    output logic [SLV_ID_W-1:0]                     dsp_AR_slv_id_o,
    output logic                                    dsp_AR_disable_o
);

    localparam int AW = $clog2(DSP_AR_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [SLV_ID_W-1:0] MAX_ID = SLV_ID_W'(SLV_AMT - 1);

    logic [SLV_ID_W-1:0]          dec_raw;
    logic [SLV_ID_W-1:0]          dec_id;
    logic                         valid_q;
    logic [SLV_ID_W-1:0]          tgt_q;
    logic [TRANS_MST_ID_W-1:0]    id_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [TRANS_BURST_W-1:0]     burst_q;
    logic [TRANS_DATA_LEN_W-1:0]  len_q;
    logic [TRANS_DATA_SIZE_W-1:0] size_q;
    logic                         out_hs;
    logic                         m_hs;
    logic                         r_done;
    logic [SLV_ID_W-1:0]          ord_mem [DSP_AR_DEPTH];
    logic [PW-1:0]                wptr;
    logic [PW-1:0]                rptr;
    logic                         ord_empty;
    logic                         ord_full;

    // Unused high encodings fold onto the last slave
    assign dec_raw = m_ARADDR_i[ADDR_WIDTH-1 -: SLV_ID_W];
    assign dec_id  = (dec_raw > MAX_ID) ? MAX_ID : dec_raw;

    genvar k;
    generate
        for (k = 0; k < SLV_AMT; k++) begin : g_vld
            assign sa_ARVALID_o[k] = valid_q & (tgt_q == SLV_ID_W'(k));
        end
    endgenerate

    assign sa_ARID_o    = {SLV_AMT{id_q}};
    assign sa_ARADDR_o  = {SLV_AMT{addr_q}};
    assign sa_ARBURST_o = {SLV_AMT{burst_q}};
    assign sa_ARLEN_o   = {SLV_AMT{len_q}};
    assign sa_ARSIZE_o  = {SLV_AMT{size_q}};

    assign out_hs      = |(sa_ARVALID_o & sa_ARREADY_i);
    assign ord_empty   = (wptr == rptr);
    assign ord_full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // No full bypass: a pop in the same cycle does not free a slot yet
    assign m_ARREADY_o = ~ord_full & (~valid_q | out_hs);
    assign m_hs        = m_ARVALID_i & m_ARREADY_o;
    assign r_done      = m_RVALID_i & m_RREADY_i & m_RLAST_i & ~ord_empty;

    assign dsp_AR_slv_id_o  = ord_mem[rptr[AW-1:0]];
    assign dsp_AR_disable_o = ord_empty;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            valid_q <= 1'b0;
            tgt_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
        end else if (m_hs) begin
            valid_q <= 1'b1;
            tgt_q   <= dec_id;
            id_q    <= m_ARID_i;
            addr_q  <= m_ARADDR_i;
            burst_q <= m_ARBURST_i;
            len_q   <= m_ARLEN_i;
            size_q  <= m_ARSIZE_i;
        end else if (out_hs) begin
            valid_q <= 1'b0;
        end
    end

    // Slave order is recorded at master acceptance so it tracks master issue order
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DSP_AR_DEPTH; i++) begin
                ord_mem[i] <= '0;
            end
        end else begin
            if (m_hs) begin
                ord_mem[wptr[AW-1:0]] <= dec_id;
                wptr                  <= wptr + PW'(1);
            end
            if (r_done) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dsp_ar_channel.sv
// tb/tb_dsp_ar_channel.sv - scoreboard bench for dsp_ar_channel
module tb_dsp_ar_channel;

    localparam int NS    = 3;
    localparam int AWID  = 32;
    localparam int IDW   = 5;
    localparam int BW    = 2;
    localparam int LW    = 8;
    localparam int SW    = 3;
    localparam int SIDW  = 2;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [IDW-1:0]       m_arid;
    logic [AWID-1:0]      m_araddr;
    logic [BW-1:0]        m_arburst;
    logic [LW-1:0]        m_arlen;
    logic [SW-1:0]        m_arsize;
    logic                 m_arvalid;
    logic                 m_arready;
    logic                 rv, rr, rl;
    logic [IDW*NS-1:0]    sa_arid;
    logic [AWID*NS-1:0]   sa_araddr;
    logic [BW*NS-1:0]     sa_arburst;
    logic [LW*NS-1:0]     sa_arlen;
    logic [SW*NS-1:0]     sa_arsize;
    logic [NS-1:0]        sa_arvalid;
    logic [NS-1:0]        sa_arready;
    logic [SIDW-1:0]      slv_id;
    logic                 dis;

    dsp_ar_channel #(
        .SLV_AMT(NS), .ADDR_WIDTH(AWID), .TRANS_MST_ID_W(IDW), .TRANS_BURST_W(BW),
        .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW), .SLV_ID_W(SIDW), .DSP_AR_DEPTH(DEPTH)
    ) dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .m_ARID_i(m_arid), .m_ARADDR_i(m_araddr), .m_ARBURST_i(m_arburst),
        .m_ARLEN_i(m_arlen), .m_ARSIZE_i(m_arsize), .m_ARVALID_i(m_arvalid),
        .m_ARREADY_o(m_arready),
        .m_RVALID_i(rv), .m_RREADY_i(rr), .m_RLAST_i(rl),
        .sa_ARID_o(sa_arid), .sa_ARADDR_o(sa_araddr), .sa_ARBURST_o(sa_arburst),
        .sa_ARLEN_o(sa_arlen), .sa_ARSIZE_o(sa_arsize), .sa_ARVALID_o(sa_arvalid),
        .sa_ARREADY_i(sa_arready),
        .dsp_AR_slv_id_o(slv_id), .dsp_AR_disable_o(dis)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              tgt;
        logic [AWID-1:0] addr;
        logic [IDW-1:0]  id;
        logic [BW-1:0]   burst;
        logic [LW-1:0]   len;
        logic [SW-1:0]   size;
    } ar_t;

    ar_t out_q[$];
    int  ord_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input logic [AWID-1:0] a);
        int t;
        t = int'(a >> (AWID - SIDW));
        return (t > NS - 1) ? NS - 1 : t;
    endfunction

    // Reference model: one pending slave request plus an ordered list of outstanding slaves
    always @(negedge clk) begin
        if (!rst_n) begin
            out_q.delete();
            ord_q.delete();
        end else begin
            automatic bit    ohs;
            automatic bit    rdy;
            automatic bit    rdone;
            automatic int    exp_v = 0;
            automatic ar_t   a;
            chk("disable", dis, ord_q.size() == 0);
            if (ord_q.size() > 0) chk("slv_id", slv_id, ord_q[0]);
            if (out_q.size() > 0) begin
                exp_v = 1 << out_q[0].tgt;
                for (int i = 0; i < NS; i++) begin
                    chk("sa_addr", sa_araddr[i*AWID +: AWID], out_q[0].addr);
                    chk("sa_id", sa_arid[i*IDW +: IDW], out_q[0].id);
                    chk("sa_misc", {sa_arburst[i*BW +: BW], sa_arlen[i*LW +: LW], sa_arsize[i*SW +: SW]},
                        {out_q[0].burst, out_q[0].len, out_q[0].size});
                end
            end
            chk("sa_valid", sa_arvalid, exp_v);
            ohs   = (out_q.size() > 0) && sa_arready[out_q[0].tgt];
            rdy   = (ord_q.size() < DEPTH) && ((out_q.size() == 0) || ohs);
            chk("m_ready", m_arready, rdy);
            rdone = rv && rr && rl && (ord_q.size() > 0);
            if (ohs) void'(out_q.pop_front());
            if (rdone) void'(ord_q.pop_front());
            if (m_arvalid && rdy) begin
                a.tgt = tgt_of(m_araddr); a.addr = m_araddr; a.id = m_arid;
                a.burst = m_arburst; a.len = m_arlen; a.size = m_arsize;
                out_q.push_back(a);
                ord_q.push_back(a.tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input logic [AWID-1:0] a, input logic [IDW-1:0] id, input logic [LW-1:0] len);
        m_arvalid = 1'b1;
        m_araddr  = a;
        m_arid    = id;
        m_arlen   = len;
        m_arburst = BW'($urandom);
        m_arsize  = SW'($urandom);
    endtask

    task automatic drain();
        rv = 1'b1; rr = 1'b1; rl = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dis) break;
            tick();
        end
        chk("drain_timeout", dis, 1'b1);
        tick();
        rv = 1'b0; rr = 1'b0; rl = 1'b0;
    endtask

    initial begin
        automatic int    exp_ord[3] = '{0, 1, 0};
        automatic logic [AWID-1:0] ord_addr[3] = '{32'h0000_0100, 32'h4000_0200, 32'h1000_0300};
        automatic bit    hs_prev = 1'b0;

        rst_n = 1'b0;
        m_arvalid = 1'b0; m_araddr = '0; m_arid = '0; m_arburst = '0; m_arlen = '0; m_arsize = '0;
        rv = 1'b0; rr = 1'b0; rl = 1'b0; sa_arready = '1;
        repeat (3) tick();
        chk("rst_valid", sa_arvalid, 0);
        chk("rst_disable", dis, 1);
        chk("rst_slv_id", slv_id, 0);
        chk("rst_addr", sa_araddr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", m_arready, 1);
        tick();

        // Single read to slave 1, four beats
        set_ar(32'h4000_0010, 5'd3, 8'd3);
        tick();
        m_arvalid = 1'b0;
        @(negedge clk);
        chk("single_valid", sa_arvalid, 3'b010);
        chk("single_addr", sa_araddr[1*AWID +: AWID], 32'h4000_0010);
        chk("single_id", sa_arid[1*IDW +: IDW], 3);
        chk("single_dis", dis, 0);
        chk("single_slv", slv_id, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            rv = 1'b1; rr = 1'b1; rl = (i == 3);
            if (i < 3) begin
                @(negedge clk);
                chk("single_beat_dis", dis, 0);
            end
            tick();
        end
        rv = 1'b0; rr = 1'b0; rl = 1'b0;
        @(negedge clk);
        chk("single_done_dis", dis, 1);
        tick();

        // Ordering 0,1,0
        for (int i = 0; i < 3; i++) begin
            set_ar(ord_addr[i], IDW'(i), 8'd0);
            tick();
        end
        m_arvalid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("order_slv", slv_id, exp_ord[i]);
            tick();
            rv = 1'b1; rr = 1'b1; rl = 1'b1;
            tick();
            rv = 1'b0; rr = 1'b0; rl = 1'b0;
        end
        @(negedge clk);
        chk("order_dis", dis, 1);
        tick();

        // Clamp of unused encoding 2'b11
        set_ar(32'hC000_0000, 5'd9, 8'd1);
        tick();
        m_arvalid = 1'b0;
        @(negedge clk);
        chk("clamp_valid", sa_arvalid, 3'b100);
        chk("clamp_slv", slv_id, 2);
        tick();
        drain();

        // Full FIFO, RLAST in the same cycle as a fifth request
        for (int i = 0; i < DEPTH; i++) begin
            set_ar($urandom, IDW'($urandom), LW'($urandom));
            tick();
        end
        set_ar(32'h0000_0040, 5'd7, 8'd0);
        @(negedge clk);
        chk("full_ready", m_arready, 0);
        tick();
        rv = 1'b1; rr = 1'b1; rl = 1'b1;
        @(negedge clk);
        chk("full_nobypass", m_arready, 0);
        tick();
        rv = 1'b0; rr = 1'b0; rl = 1'b0;
        @(negedge clk);
        chk("full_reready", m_arready, 1);
        tick();
        m_arvalid = 1'b0;
        drain();

        // Slave backpressure for five cycles
        sa_arready = '0;
        set_ar(32'h4000_0abc, 5'd1, 8'd2);
        tick();
        set_ar(32'h8000_0def, 5'd2, 8'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", m_arready, 0);
            chk("bp_addr", sa_araddr[1*AWID +: AWID], 32'h4000_0abc);
            tick();
        end
        sa_arready = '1;
        @(negedge clk);
        chk("bp_release_ready", m_arready, 1);
        tick();
        m_arvalid = 1'b0;
        tick();
        drain();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            sa_arready = NS'($urandom);
            rv = ($urandom % 3) != 0;
            rr = ($urandom % 3) != 0;
            rl = ($urandom % 3) == 0;
            if (!m_arvalid || hs_prev) begin
                if (($urandom % 4) != 0) set_ar($urandom, IDW'($urandom), LW'($urandom));
                else m_arvalid = 1'b0;
            end
            @(negedge clk);
            hs_prev = m_arvalid && m_arready;
            tick();
        end
        m_arvalid = 1'b0;
        sa_arready = '1;
        rv = 1'b0; rr = 1'b0; rl = 1'b0;
        tick();
        drain();

        // Asynchronous reset with requests in flight
        sa_arready = '0;
        set_ar(32'h8000_0004, 5'd4, 8'd1);
        tick();
        m_arvalid = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", sa_arvalid, 0);
        chk("arst_disable", dis, 1);
        chk("arst_slv_id", slv_id, 0);
        sa_arready = '1;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", m_arready, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_ar_channel.md
Name: dsp_ar_channel

Overview:
Per-master AR dispatcher that sits directly upstream of the RDATA dispatcher. It accepts AXI4 read-address requests from one master and decodes the target slave from the address MSBs. It forwards each request through a one-entry output register to that slave's arbitration port, and records the slave ID in an in-order FIFO. The FIFO head drives the RDATA dispatcher's select (slv_id) and disable inputs; the head is retired on each master-side R handshake with RLAST.

Parameters:
SLV_AMT, 2, number of slaves (>=2)
ADDR_WIDTH, 32, AR address width
TRANS_MST_ID_W, 5, transaction ID width
TRANS_BURST_W, 2, ARBURST width
TRANS_DATA_LEN_W, 8, ARLEN width
TRANS_DATA_SIZE_W, 3, ARSIZE width
SLV_ID_W, $clog2(SLV_AMT), slave index width
DSP_AR_DEPTH, 4, max outstanding read bursts (power of 2, >=2)

Ports:
ACLK_i  in  1  clock
ARESETn_i  in  1  reset, asynchronous, active-low
m_ARID_i  in  TRANS_MST_ID_W  master ARID
m_ARADDR_i  in  ADDR_WIDTH  master ARADDR
m_ARBURST_i  in  TRANS_BURST_W  master ARBURST
m_ARLEN_i  in  TRANS_DATA_LEN_W  master ARLEN
m_ARSIZE_i  in  TRANS_DATA_SIZE_W  master ARSIZE
m_ARVALID_i  in  1  master AR valid
m_ARREADY_o  out  1  AR ready to master
m_RVALID_i  in  1  master-side RVALID (from RDATA dispatcher)
m_RREADY_i  in  1  master RREADY
m_RLAST_i  in  1  master-side RLAST
sa_ARID_o  out  TRANS_MST_ID_W*SLV_AMT  per-slave replicated ARID
sa_ARADDR_o  out  ADDR_WIDTH*SLV_AMT  per-slave ARADDR
sa_ARBURST_o  out  TRANS_BURST_W*SLV_AMT  per-slave ARBURST
sa_ARLEN_o  out  TRANS_DATA_LEN_W*SLV_AMT  per-slave ARLEN
sa_ARSIZE_o  out  TRANS_DATA_SIZE_W*SLV_AMT  per-slave ARSIZE
sa_ARVALID_o  out  SLV_AMT  one-hot AR valid to slave arbitration
sa_ARREADY_i  in  SLV_AMT  AR ready from slave arbitration
dsp_AR_slv_id_o  out  SLV_ID_W  slave ID of oldest outstanding burst
dsp_AR_disable_o  out  1  1 = no outstanding burst

Behaviour:
- Clock and reset: single clock ACLK_i. ARESETn_i is asynchronous and active-low. On reset, the output register is invalid (sa_ARVALID_o=0, payload registers 0), the order FIFO is empty with pointers=0, dsp_AR_slv_id_o=0 and dsp_AR_disable_o=1. m_ARREADY_o=1 once reset is released.
- Decode: dec_id = m_ARADDR_i[ADDR_WIDTH-1 -: SLV_ID_W]. If dec_id >= SLV_AMT, it is clamped to SLV_AMT-1.
- Output register: holds a valid flag, the payload and the target id.
  - sa_ARVALID_o[k] = valid & (tgt==k).
  - The payload is replicated on every slice of the sa_* buses.
  - out_hs = sa_ARVALID_o[tgt] & sa_ARREADY_i[tgt].
- Master acceptance: m_ARREADY_o = ~ord_full & (~valid | out_hs). m_hs = m_ARVALID_i & m_ARREADY_o.
- Output register update: on m_hs, load payload and dec_id and set valid. Otherwise, on out_hs, clear valid. Latency from master AR handshake to sa_ARVALID_o is 1 cycle. Back-to-back issue at 1/cycle is supported when the slave is always ready.
- Order FIFO: depth DSP_AR_DEPTH, width SLV_ID_W, pointers of log2(depth)+1 bits.
  - Push dec_id on m_hs. Push happens at acceptance, not at slave issue, so ordering equals master order.
  - Pop on r_done = m_RVALID_i & m_RREADY_i & m_RLAST_i & ~ord_empty.
- FIFO outputs: dsp_AR_slv_id_o = head entry (registered storage, combinational read). dsp_AR_disable_o = ord_empty.
- Simultaneous push and pop: both happen and the occupancy is unchanged. When empty, a push makes disable fall on the next cycle with slv_id = the pushed id.
- Full: m_ARREADY_o=0 even if r_done occurs in the same cycle (no bypass). Ready reasserts the cycle after the pop.
- Stall: while sa_ARREADY_i[tgt]=0, the payload and sa_ARVALID_o are held stable (AXI rule). No new request is accepted.
- Non-LAST R handshakes and RLAST with ord_empty do not change FIFO state.
- Reset mid-operation: all state is cleared immediately and any in-flight burst is dropped.

Test Plan:
- Reset: assert ARESETn_i=0 mid-burst → sa_ARVALID_o=0, dsp_AR_disable_o=1, dsp_AR_slv_id_o=0 asynchronously; after release m_ARREADY_o=1.
- Single read: SLV_AMT=2, ARADDR=0x8000_0010, ARID=3, ARLEN=3 → next cycle sa_ARVALID_o=2'b10 with ARADDR/ARID on slice 1; disable=0 and slv_id=1; after 4 R beats with RLAST on the 4th, disable=1.
- Ordering: issue ARs to slaves 0,1,0 back-to-back → slv_id sequence 0,1,0 with one change per RLAST handshake; sa_ARVALID_o one-hot each cycle.
- Full: DSP_AR_DEPTH=4, 4 accepted ARs with no R traffic → m_ARREADY_o=0. An RLAST handshake in the same cycle as a 5th ARVALID → 5th accepted the next cycle, not the same cycle.
- Backpressure: sa_ARREADY_i=0 for 5 cycles → sa_* payload stable and m_ARREADY_o=0. When ready rises, out_hs and a new m_hs occur in the same cycle.
- Clamp: SLV_AMT=3, ARADDR MSBs=2'b11 → routed to slave 2, slv_id=2.
